// File: rtl/datamem_seq.sv
// Byte-addressed data memory on the LSU port: valid/ready requests, registered
// responses, range checking and optional two-cycle handling of word-crossing accesses.
module datamem_seq #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int MISALIGN_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        WriteEn,
  input  logic [31:0] address,
  input  logic [31:0] datain,
  input  logic [1:0]  datasize,
  input  logic        datatype,
  output logic        rsp_valid,
  output logic [31:0] dataout,
  output logic        misalign_err,
  output logic        range_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam bit          SPLIT_EN   = (MISALIGN_MODE != 0);

  typedef enum logic {IDLE, PHASE2} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH_WORDS];

  // Request decode
  logic [2:0]    nbytes;
  logic [3:0]    mask4;
  logic [1:0]    off;
  logic [32:0]   last_byte;
  logic          accept;
  logic          out_of_range;
  logic          misaligned;
  logic          crossing;
  logic          reject;
  logic [7:0]    be_win;
  logic [63:0]   data_win;
  logic [AW-1:0] idx_a;
  logic [31:0]   rd_word;

  // Context carried from the first phase of a split access into the second
  logic [AW-1:0] p2_idx;
  logic [31:0]   p2_data;
  logic [3:0]    p2_be;
  logic          p2_write;
  logic [1:0]    p2_off;
  logic [2:0]    p2_nbytes;
  logic          p2_unsigned;
  logic [31:0]   hold_word;

  // Single write port, shared by single-phase/phase-1 writes and phase-2 writes
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  function automatic logic [31:0] load_ext(input logic [63:0] win, input logic [1:0] sh_off,
                                           input logic [2:0] nb, input logic uns);
    logic [31:0] sh;
    sh = 32'(win >> {sh_off, 3'b000});
    case (nb)
      3'd1:    load_ext = {{24{~uns & sh[7]}}, sh[7:0]};
      3'd2:    load_ext = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  assign accept = req_valid && req_ready;
  assign off    = address[1:0];
  assign idx_a  = address[AW+1:2];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nbytes = 3'd4;
    mask4  = 4'b1111;
    case (datasize)
      2'b01: begin nbytes = 3'd2; mask4 = 4'b0011; end
      2'b10: begin nbytes = 3'd1; mask4 = 4'b0001; end
      default: ;
    endcase
  end

  // The carry into bit 32 keeps accesses near the top of the address space from wrapping into range.
  assign last_byte    = {1'b0, address} + {30'b0, nbytes} - 33'd1;
  assign out_of_range = (last_byte >= BYTE_LIMIT);
  assign misaligned   = ((nbytes == 3'd2) && off[0]) || ((nbytes == 3'd4) && (off != 2'b00));
  assign crossing     = (({1'b0, off} + nbytes) > 3'd4);
  assign reject       = out_of_range || (misaligned && !SPLIT_EN);

  // The access is placed in an 8-byte window: low half is word A, high half is word A+1.
  assign data_win = {32'b0, datain} << {off, 3'b000};
  assign be_win   = {4'b0, mask4} << off;
  assign rd_word  = mem[idx_a];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = idx_a;
    wr_data = data_win[31:0];
    wr_be   = be_win[3:0];
    if (state == PHASE2) begin
      wr_en   = p2_write;
      wr_idx  = p2_idx;
      wr_data = p2_data;
      wr_be   = p2_be;
    end else if (accept && WriteEn && !reject) begin
      wr_en = 1'b1;
    end
    // An aborted second phase must not write; the first phase has already committed.
    if (!reset) wr_en = 1'b0;
  end

  // NOTE: the array has no reset; only control state is cleared, the contents survive.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && crossing) begin
      p2_idx      <= idx_a + AW'(1);
      p2_data     <= data_win[63:32];
      p2_be       <= be_win[7:4];
      p2_write    <= WriteEn;
      p2_off      <= off;
      p2_nbytes   <= nbytes;
      p2_unsigned <= datatype;
      hold_word   <= rd_word;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      dataout      <= 32'h0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (out_of_range) begin
              rsp_valid <= 1'b1;
              range_err <= 1'b1;
              dataout   <= 32'h0;
            end else if (misaligned && !SPLIT_EN) begin
              rsp_valid    <= 1'b1;
              misalign_err <= 1'b1;
              dataout      <= 32'h0;
            end else if (crossing) begin
              state     <= PHASE2;
              req_ready <= 1'b0;
            end else begin
              rsp_valid <= 1'b1;
              dataout   <= WriteEn ? 32'h0 : load_ext({32'h0, rd_word}, off, nbytes, datatype);
            end
          end
        end
        PHASE2: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          dataout   <= p2_write ? 32'h0
                                : load_ext({mem[p2_idx], hold_word}, p2_off, p2_nbytes, p2_unsigned);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_seq.sv
// Randomised scoreboard bench for datamem_seq: one instance per misalign mode, checked
// against a byte-array reference model with an independent response monitor.
module tb_datamem_seq;

  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  typedef struct {
    logic [31:0] data;
    bit          mis;
    bit          rng;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        WriteEn;
  logic [31:0] address;
  logic [31:0] datain;
  logic [1:0]  datasize;
  logic        datatype;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  misalign_err;
  logic [1:0]  range_err;
  logic [31:0] dataout [2];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem_m [2][NBYTES];
  exp_t        sbq [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: trap misaligned accesses; index 1: split word-crossing accesses.
  datamem_seq #(.DEPTH_WORDS(DEPTH), .MISALIGN_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .WriteEn(WriteEn), .address(address), .datain(datain), .datasize(datasize),
    .datatype(datatype), .rsp_valid(rsp_valid[0]), .dataout(dataout[0]),
    .misalign_err(misalign_err[0]), .range_err(range_err[0])
  );

  datamem_seq #(.DEPTH_WORDS(DEPTH), .MISALIGN_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .WriteEn(WriteEn), .address(address), .datain(datain), .datasize(datasize),
    .datatype(datatype), .rsp_valid(rsp_valid[1]), .dataout(dataout[1]),
    .misalign_err(misalign_err[1]), .range_err(range_err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, want, cyc);
  endtask

  // Reference model: a plain byte array; applies the access rules directly.
  function automatic void predict(input int m, input bit we, input logic [31:0] a,
                                  input logic [31:0] d, input logic [1:0] sz, input bit dt,
                                  input bit p1_only, output exp_t e, output int lat);
    int          n;
    longint      last;
    logic [31:0] v;
    n      = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    e.data = 32'h0;
    e.mis  = 1'b0;
    e.rng  = 1'b0;
    e.due  = 0;
    lat    = 1;
    last   = longint'({32'h0, a}) + n - 1;
    if (last >= NBYTES) begin
      e.rng = 1'b1;
    end else if (m == 0 && (a % n) != 0) begin
      e.mis = 1'b1;
    end else begin
      if ((a % 4) + n > 4) lat = 2;
      if (we) begin
        for (int i = 0; i < n; i++) begin
          if (!p1_only || ((a + i) / 4 == a / 4)) mem_m[m][a + i] = d[8*i +: 8];
        end
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[m][a + i];
        if (!dt && n == 1 && v[7])  v[31:8]  = '1;
        if (!dt && n == 2 && v[15]) v[31:16] = '1;
        e.data = v;
      end
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit dt);
    exp_t e;
    int   lat;
    int   waited;
    waited   = 0;
    WriteEn  = we;
    address  = a;
    datain   = d;
    datasize = sz;
    datatype = dt;
    req_valid[m] = 1'b1;
    while (!req_ready[m] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[m]) begin
      fail($sformatf("m%0d_ready_timeout", m), 32'(req_ready[m]), 32'h1);
      req_valid[m] = 1'b0;
      return;
    end
    predict(m, we, a, d, sz, dt, 1'b0, e, lat);
    e.due = cyc + lat;
    sbq[m].push_back(e);
    @(negedge clk);
    req_valid[m] = 1'b0;
    check($sformatf("m%0d_ready_after_accept", m), 32'(req_ready[m]), (lat == 2) ? 32'h0 : 32'h1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (sbq[0].size() != 0 || sbq[1].size() != 0); k++) @(negedge clk);
    if (sbq[0].size() != 0 || sbq[1].size() != 0)
      fail("drain_timeout", 32'(sbq[0].size() + sbq[1].size()), 32'h0);
  endtask

  // Split access on the mode-1 instance with reset asserted during its second phase.
  task automatic split_reset(input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    WriteEn  = we;
    address  = a;
    datain   = d;
    datasize = 2'b00;
    datatype = 1'b0;
    req_valid[1] = 1'b1;
    check("split_start_ready", 32'(req_ready[1]), 32'h1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    predict(1, we, a, d, 2'b00, 1'b0, 1'b1, e, lat);
    check("split_phase2_ready", 32'(req_ready[1]), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("split_abort_rsp_valid", 32'(rsp_valid[1]), 32'h0);
    check("split_abort_ready", 32'(req_ready[1]), 32'h1);
    check("split_abort_dataout", dataout[1], 32'h0);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      if (rsp_valid[m]) begin
        if (sbq[m].size() == 0) begin
          fail($sformatf("m%0d_unexpected_rsp", m), dataout[m], 32'h0);
        end else begin
          e = sbq[m].pop_front();
          check($sformatf("m%0d_rsp_cycle", m), 32'(cyc), 32'(e.due));
          check($sformatf("m%0d_dataout", m), dataout[m], e.data);
          check($sformatf("m%0d_misalign_err", m), 32'(misalign_err[m]), 32'(e.mis));
          check($sformatf("m%0d_range_err", m), 32'(range_err[m]), 32'(e.rng));
        end
      end else begin
        check($sformatf("m%0d_idle_flags", m), {30'h0, misalign_err[m], range_err[m]}, 32'h0);
        if (sbq[m].size() != 0 && sbq[m][0].due <= cyc) begin
          fail($sformatf("m%0d_missing_rsp", m), 32'(cyc), 32'(sbq[m][0].due));
          void'(sbq[m].pop_front());
        end
      end
    end
  end

  initial begin
    int          m;
    int          sel;
    logic [31:0] a;
    reset     = 1'b0;
    req_valid = 2'b00;
    WriteEn   = 1'b0;
    address   = 32'h0;
    datain    = 32'h0;
    datasize  = 2'b00;
    datatype  = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m%0d_reset_ready", i), 32'(req_ready[i]), 32'h1);
      check($sformatf("m%0d_reset_rsp_valid", i), 32'(rsp_valid[i]), 32'h0);
      check($sformatf("m%0d_reset_dataout", i), dataout[i], 32'h0);
      check($sformatf("m%0d_reset_errs", i), {30'h0, misalign_err[i], range_err[i]}, 32'h0);
    end
    reset = 1'b1;

    // Give every byte the bench will read a known value, in both instances.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) issue(i, 1'b1, 32'(4 * w), $urandom, 2'b00, 1'b0);
      for (int w = DEPTH - 16; w < DEPTH; w++) issue(i, 1'b1, 32'(4 * w), $urandom, 2'b00, 1'b0);
    end

    // Aligned traffic and the split cases on the mode-1 instance.
    issue(1, 1'b1, 32'h0C, 32'h1122_3344, 2'b00, 1'b0);
    issue(1, 1'b0, 32'h0C, 32'h0, 2'b00, 1'b0);
    issue(1, 1'b1, 32'h0E, 32'hAABB_CCDD, 2'b00, 1'b0);
    issue(1, 1'b0, 32'h0C, 32'h0, 2'b00, 1'b0);
    issue(1, 1'b0, 32'h0E, 32'h0, 2'b00, 1'b0);
    issue(1, 1'b0, 32'h0F, 32'h0, 2'b01, 1'b0);
    issue(1, 1'b0, 32'h0F, 32'h0, 2'b01, 1'b1);
    issue(1, 1'b0, 32'h0F, 32'h0, 2'b10, 1'b0);

    // Trapping mode: misaligned stores leave memory untouched.
    issue(0, 1'b1, 32'h0C, 32'h1122_3344, 2'b00, 1'b0);
    issue(0, 1'b1, 32'h0E, 32'h5566_7788, 2'b00, 1'b0);
    issue(0, 1'b0, 32'h0C, 32'h0, 2'b00, 1'b0);
    issue(0, 1'b0, 32'h0D, 32'h0, 2'b01, 1'b0);

    // Range edges.
    issue(1, 1'b0, 32'h1000, 32'h0, 2'b00, 1'b0);
    issue(0, 1'b0, 32'h1000, 32'h0, 2'b00, 1'b0);
    issue(1, 1'b1, 32'hFFE, 32'h0BAD_F00D, 2'b00, 1'b0);
    issue(1, 1'b0, 32'hFFC, 32'h0, 2'b00, 1'b0);
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b00, 1'b0);
    drain();

    // Reset during the second phase of a split load, then of a split store.
    split_reset(1'b0, 32'h0E, 32'h0);
    issue(1, 1'b0, 32'h0C, 32'h0, 2'b00, 1'b0);
    drain();
    split_reset(1'b1, 32'h1E, 32'h9988_7766);
    issue(1, 1'b0, 32'h1C, 32'h0, 2'b00, 1'b0);
    issue(1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);

    for (int k = 0; k < 400; k++) begin
      m   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = $urandom_range(0, 124);
      else if (sel < 9) a = $urandom_range(NBYTES - 64, NBYTES - 1);
      else              a = $urandom_range(NBYTES, 32'hFFFF_FFFF);
      issue(m, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datamem_seq.md
Name: datamem_seq

Overview:
Parametrised successor to the single-cycle data memory. It keeps byte/half/word accesses with signed or unsigned load extension. It adds a valid/ready request handshake, registered responses, range checking, and a mode that splits word-crossing misaligned accesses into two cycles. It sits on the LSU data port and is the first memory in the design that can stall the core.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1
MISALIGN_MODE, 1, 0 = trap any misaligned access; 1 = support it, splitting word-crossing cases into two cycles

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
WriteEn  in  1  1 = store, 0 = load
address  in  32  byte address, little-endian
datain  in  32  store data, right-justified for half/byte
datasize  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
datatype  in  1  0 = signed load, 1 = unsigned load
rsp_valid  out  1  one-cycle pulse; response fields valid
dataout  out  32  load result, extended to 32 bits; 0 for stores and errors
misalign_err  out  1  valid with rsp_valid; misaligned access rejected (MISALIGN_MODE=0)
range_err  out  1  valid with rsp_valid; access touches a byte at or above 4*DEPTH_WORDS

Behaviour:
- Handshake and inputs
  - Accept occurs when req_valid && req_ready at a rising edge.
  - WriteEn, address, datain, datasize and datatype are sampled at accept.
  - Requests presented while req_ready=0 are ignored; the requester holds them.
- Reset (reset=0 at an edge)
  - Outputs: req_ready=1, rsp_valid=0, dataout=0, misalign_err=0, range_err=0.
  - FSM returns to IDLE.
  - Memory array is not cleared.
- Reset mid-split
  - Aborts the split; no response is issued.
  - The phase-1 portion of a split store stays committed.
- Access classes, from address[1:0] and size (1, 2 or 4 bytes)
  - Aligned, or misaligned within one word (e.g. half at offset 1): single-phase.
  - Crossing a word boundary (half at offset 3; word at offset 1, 2 or 3): split.
- Single-phase access accepted at edge T
  - Store: byte-enabled write at edge T.
  - Load: word read at edge T; selected bytes are shifted down and extended.
  - rsp_valid=1 during cycle T+1; req_ready stays 1, so back-to-back accepts are allowed.
- Split access, MISALIGN_MODE=1, accepted at edge T
  - State goes IDLE -> PHASE2; req_ready=0 during cycle T+1.
  - Phase 1 (edge T): covers the bytes in word A = address[31:2].
    - Store: writes those bytes at edge T.
    - Load: captures those bytes into a holding register.
  - Phase 2 (edge T+1): covers the remaining bytes in word A+1.
    - Store: writes them.
    - Load: reads them and assembles the result with the held bytes.
  - rsp_valid=1 during cycle T+2; state returns to IDLE with req_ready=1.
- Misaligned access, MISALIGN_MODE=0
  - No memory write occurs.
  - rsp_valid at T+1 with misalign_err=1 and dataout=0.
- Range check
  - Performed at accept, on the last byte touched.
  - Out-of-range access: no write to either word, no split, rsp_valid at T+1 with range_err=1 and dataout=0.
  - Range check takes precedence over the misalign check.
- Load extension
  - Half: bit 15 sign-extended (datatype=0) or zero-extended (datatype=1).
  - Byte: bit 7 sign-extended (datatype=0) or zero-extended (datatype=1).
  - Word: datatype is ignored.
- Output hold
  - dataout holds its last value between responses; error flags are 0 when rsp_valid=0.
- No read-during-write forwarding is needed
  - A load accepted the cycle after a store sees the stored data, because the store commits at its accept edge.

Test Plan:
- Word store 0x11223344 @0x0C, then word load @0x0C -> rsp_valid one cycle after each accept; load dataout=0x11223344; req_ready never drops.
- MODE=1: word store 0xAABBCCDD @0x0E -> req_ready=0 for one cycle, rsp at T+2; aligned word load @0x0C -> 0xCCDD3344; word load @0x0E -> 0xAABBCCDD at T+2.
- MODE=1, after the previous case: half load @0x0F, datatype=0 -> 0xFFFFBBCC; same with datatype=1 -> 0x0000BBCC; byte load @0x0F, datatype=0 -> 0xFFFFFFCC.
- MODE=0: word store 0x55667788 @0x0E -> rsp at T+1, misalign_err=1; aligned load @0x0C unchanged at 0x11223344. Half load @0x0D (within-word misaligned) -> also misalign_err=1.
- DEPTH_WORDS=1024: word load @0x1000 -> range_err=1, dataout=0. MODE=1 word store @0xFFE -> range_err=1 at T+1, no split, and word @0xFFC keeps its prior value.
- Drive reset=0 during PHASE2 of a split load -> no rsp_valid, req_ready=1 and dataout=0 after the reset edge; the next aligned load completes normally.
